// File: rtl/simon_pkg.sv
// Shared types and constants for the colour-sequence game blocks.
package simon_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t COLOUR_UNASSIGNED = 3'b100;
    localparam int      MAX_ROUNDS        = 32;
    localparam int      LED_W             = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ON,
        OFF,
        DONE
    } play_state_t;

endpackage

// File: rtl/sequence_player_colour_decoder.sv
// Combinational colour to one-hot LED decode; an unassigned colour (bit 2 set) gives a blank display.
module colour_decoder
    import simon_pkg::*;
(
    input  colour_t            colour,
    output logic [LED_W-1:0]   led
);

    always_comb begin
        led = '0;
        if (!colour[2]) begin
            case (colour[1:0])
                2'b00: led = 4'b0001;
                2'b01: led = 4'b0010;
                2'b10: led = 4'b0100;
                2'b11: led = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Plays a snapshot of the colour history, oldest first, paced by timer pulses.
// SEQ_PLAYER_GAP_EN inserts a blank OFF phase between consecutive colours.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | timer reloaded, display blank until first pulse
// ON    | showing snapshot[idx]
// OFF   | blank gap between colours (SEQ_PLAYER_GAP_EN only)
// DONE  | one-cycle completion strobe
module sequence_player #(
    parameter int MAX_LEN = 32,
    parameter int LED_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [5:0]              length,
    input  logic [MAX_LEN-1:0][2:0] segment,
    input  logic                    pulse,
    output logic                    timer_restart,
    output logic [LED_W-1:0]        led,
    output logic                    busy,
    output logic                    done
);

    import simon_pkg::*;

    localparam int IDX_W = $clog2(MAX_LEN);

    play_state_t              state, state_d;
    logic [IDX_W-1:0]         idx, idx_d, idx_load;
    colour_t [MAX_LEN-1:0]    snapshot, snapshot_d;
    logic                     unassigned_seen, unassigned_seen_d;
    logic                     restart_d;
    logic [5:0]               len_clamped;
    colour_t                  colour_next;
    logic [LED_W-1:0]         colour_led, led_d;

    assign len_clamped = (length > 6'(MAX_LEN)) ? 6'(MAX_LEN) : length;
    assign idx_load    = IDX_W'(len_clamped - 6'd1);

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        snapshot_d = snapshot;
        restart_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != 6'd0) begin
                        state_d    = ARM;
                        snapshot_d = segment;
                        idx_d      = idx_load;
                        restart_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ARM: begin
                if (pulse) state_d = ON;
            end
`ifdef SEQ_PLAYER_GAP_EN
            ON: begin
                if (pulse) state_d = OFF;
            end
            OFF: begin
                if (pulse) begin
                    if (idx == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx - 1'b1;
                        state_d = ON;
                    end
                end
            end
`else
            ON: begin
                if (pulse) begin
                    if (idx == '0) state_d = DONE;
                    else           idx_d   = idx - 1'b1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode from next-cycle state so the registered LED lines up with the state it belongs to.
    assign colour_next = snapshot_d[idx_d];

    colour_decoder u_colour_decoder (
        .colour (colour_next),
        .led    (colour_led)
    );

    assign led_d = (state_d == ON) ? colour_led : '0;

    assign unassigned_seen_d = ((state_d == ON) && colour_next[2])
                             | (unassigned_seen && !(state == IDLE && start));

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            snapshot        <= {MAX_LEN{COLOUR_UNASSIGNED}};
            unassigned_seen <= 1'b0;
            led             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timer_restart   <= 1'b0;
        end else begin
            state           <= state_d;
            idx             <= idx_d;
            snapshot        <= snapshot_d;
            unassigned_seen <= unassigned_seen_d;
            led             <= led_d;
            busy            <= (state_d != IDLE);
            done            <= (state_d == DONE);
            timer_restart   <= restart_d;
        end
    end

    // An unassigned slot on display must have raised the flag and blanked the LEDs.
    a_unassigned_blank : assert property (@(posedge clk) disable iff (reset)
        (state == ON && snapshot[idx][2]) |-> (unassigned_seen && led == '0));

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player: table-driven playbacks checked cycle by cycle against a frame scoreboard.
module tb_sequence_player;
    import simon_pkg::*;

    localparam int P = 4;
`ifdef SEQ_PLAYER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic             clk = 1'b0;
    logic             reset, start, pulse;
    logic [5:0]       len_in;
    logic [31:0][2:0] seg_in;
    logic             timer_restart, busy, done;
    logic [3:0]       led;

    always #5 clk = ~clk;

    sequence_player #(.MAX_LEN(32), .LED_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .length        (len_in),
        .segment       (seg_in),
        .pulse         (pulse),
        .timer_restart (timer_restart),
        .led           (led),
        .busy          (busy),
        .done          (done)
    );

    typedef struct packed {
        logic [3:0] led;
        logic       is_done;
        logic       unassigned;
    } frame_t;

    typedef struct {
        logic [5:0]  len;
        logic [95:0] seg;
        logic        inj;
        int          lat;
        int          lit;
        logic        seen;
    } vec_t;

    frame_t sb[$];
    vec_t   vecs[7];

    int checks = 0, passed = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, lit_cnt = 0;
    int tm_cnt = 0;
    logic tm_en = 1'b0, tm_pulse = 1'b0, tr_c = 1'b0;
    logic exp_busy = 1'b0, exp_done = 1'b0, exp_tr = 1'b0, exp_seen = 1'b0, last_done = 1'b0;
    logic [3:0] cur_led = 4'b0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [3:0] exp_led(input logic [2:0] c);
        case (c)
            3'b000:  return 4'b0001;
            3'b001:  return 4'b0010;
            3'b010:  return 4'b0100;
            3'b011:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int lat_for(input int n);
        if (n == 0) return 1;
        return 2 + P * ((GAP != 0) ? 2 * n + 1 : n + 1);
    endfunction

    task automatic push_frames(input logic [5:0] l, input logic [31:0][2:0] s);
        int n;
        n = (l > 6'd32) ? 32 : int'(l);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{exp_led(s[n-1-k]), 1'b0, s[n-1-k][2]});
            if (GAP != 0) sb.push_back('{4'b0000, 1'b0, 1'b0});
        end
        sb.push_back('{4'b0000, 1'b1, 1'b0});
    endtask

    task automatic pop_frame();
        frame_t f;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
            return;
        end
        f = sb.pop_front();
        cur_led = f.led;
        if (f.unassigned) exp_seen = 1'b1;
        if (f.is_done) begin
            exp_done  = 1'b1;
            last_done = 1'b1;
            tm_en     = 1'b0;
        end
    endtask

    // One clock: advance the timer model, update expectations, compare every output.
    task automatic step();
        logic pulse_was, rst_was, start_acc;
        pulse_was = tm_pulse;
        rst_was   = reset;
        start_acc = start && !exp_busy && !reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_was) tm_en = 1'b0;
        else if (tr_c) begin
            tm_cnt = P - 1;
            tm_en  = 1'b1;
        end else if (tm_en) tm_cnt = (tm_cnt == 0) ? P - 1 : tm_cnt - 1;
        exp_done = 1'b0;
        exp_tr   = 1'b0;
        if (rst_was) begin
            sb.delete();
            exp_busy  = 1'b0;
            exp_seen  = 1'b0;
            cur_led   = 4'b0000;
            last_done = 1'b0;
        end else begin
            if (last_done) begin
                exp_busy  = 1'b0;
                last_done = 1'b0;
            end
            if (start_acc) begin
                exp_busy = 1'b1;
                exp_seen = 1'b0;
                push_frames(len_in, seg_in);
                if (len_in != 6'd0) exp_tr = 1'b1;
                else pop_frame();
            end else if (pulse_was && exp_busy) begin
                pop_frame();
            end
        end
        chk("led", led, cur_led);
        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        chk("timer_restart", timer_restart, exp_tr);
        chk("unassigned_seen", dut.unassigned_seen, exp_seen);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (led !== 4'b0000) lit_cnt++;
        tr_c     = timer_restart;
        tm_pulse = tm_en && (tm_cnt == 0);
        pulse    = tm_pulse;
    endtask

    task automatic play(input logic [5:0] l, input logic [95:0] s, input logic inj,
                        input int lat, input int lit, input logic seen);
        int d0, lit0, s0;
        seg_in = s;
        len_in = l;
        start  = 1'b1;
        if (inj) pulse = 1'b1;
        d0   = done_cnt;
        lit0 = lit_cnt;
        s0   = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < 600 && done_cnt == d0; k++) step();
        chk("done_count", done_cnt - d0, 1);
        chk("latency", done_cyc - s0, lat);
        chk("lit_cycles", lit_cnt - lit0, lit);
        chk("seen_after", dut.unassigned_seen, seen);
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0][2:0] tmp;
        int d0, lit0, s0;

        reset  = 1'b1;
        start  = 1'b0;
        pulse  = 1'b0;
        len_in = 6'd0;
        seg_in = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_state", dut.state, IDLE);
        chk("rst_idx", dut.idx, 0);
        chk("rst_snapshot", dut.snapshot[7], COLOUR_UNASSIGNED);

        tmp = '1; tmp[2] = 3'b000; tmp[1] = 3'b010; tmp[0] = 3'b001;
        vecs[0] = '{6'd3, tmp, 1'b0, lat_for(3), 12, 1'b0};
        vecs[1] = '{6'd0, tmp, 1'b0, lat_for(0), 0, 1'b0};
        for (int i = 0; i < 32; i++) tmp[i] = 3'b010;
        tmp[5] = 3'b110;
        vecs[2] = '{6'd40, tmp, 1'b0, lat_for(32), 124, 1'b1};
        tmp = '1; tmp[0] = 3'b011;
        vecs[3] = '{6'd1, tmp, 1'b0, lat_for(1), 4, 1'b0};
        tmp = '1; tmp[1] = 3'b000; tmp[0] = 3'b010;
        vecs[4] = '{6'd2, tmp, 1'b0, lat_for(2), 8, 1'b0};
        for (int i = 0; i < 32; i++) tmp[i] = 3'(i % 4);
        vecs[5] = '{6'd32, tmp, 1'b1, lat_for(32), 128, 1'b0};
        for (int i = 0; i < 32; i++) tmp[i] = 3'b001;
        vecs[6] = '{6'd63, tmp, 1'b0, lat_for(32), 128, 1'b0};

        for (int v = 0; v < 7; v++)
            play(vecs[v].len, vecs[v].seg, vecs[v].inj, vecs[v].lat, vecs[v].lit, vecs[v].seen);

        // Live segment change plus a start request while busy: playback must follow the snapshot.
        tmp = '1; tmp[2] = 3'b000; tmp[1] = 3'b010; tmp[0] = 3'b001;
        seg_in = tmp;
        len_in = 6'd3;
        start  = 1'b1;
        d0 = done_cnt; lit0 = lit_cnt; s0 = cyc;
        step();
        start = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 32; i++) seg_in[i] = 3'b011;
        len_in = 6'd5;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 600 && done_cnt == d0; k++) step();
        chk("mid_latency", done_cyc - s0, lat_for(3));
        chk("mid_lit_cycles", lit_cnt - lit0, 12);
        repeat (40) step();
        chk("mid_done_count", done_cnt - d0, 1);

        // Reset while a colour is lit, then a fresh single-colour playback.
        tmp = '1; tmp[2] = 3'b010; tmp[1] = 3'b000; tmp[0] = 3'b001;
        seg_in = tmp;
        len_in = 6'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 50 && led !== 4'b0100; k++) step();
        chk("reach_on", led, 4'b0100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_mid_state", dut.state, IDLE);
        chk("reset_mid_idx", dut.idx, 0);
        tmp = '1; tmp[0] = 3'b011;
        play(6'd1, tmp, 1'b0, lat_for(1), 4, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Read side of the colour history: snapshots the stored segment array and plays the round's colours, oldest first, on one-hot LEDs.
- Paced by `pulse` ticks from variable_timer.
- Started by the game FSM before the player's turn; signals completion with a one-cycle `done`.

Parameters:
- MAX_LEN, 32, depth of the segment array and maximum playable length.
- LED_W, 4, LED outputs, one per colour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  one-cycle request to begin playback; ignored while busy
- length  in  6  number of colours to play, 0..32; values >32 clamp to 32
- segment  in  32x3  packed colour history; segment[0] newest; bit 2 set = unassigned slot
- pulse  in  1  timer tick, one cycle wide
- timer_restart  out  1  one-cycle request to reload the timer (drives load_speed)
- led  out  4  one-hot colour display; 0000 = blank
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle completion strobe

Behaviour:
- Reset values: state=IDLE, led=0000, busy=0, done=0, timer_restart=0, idx=0, snapshot cleared to 3'b100 in every slot.
- IDLE:
  - start && length!=0: in the same cycle, latch segment into the snapshot, set idx=min(length,32)-1, and assert timer_restart; go to ARM.
  - start && length==0: go to DONE with no timer_restart.
- ARM: led=0. On pulse go to ON. A pulse in the start cycle itself is ignored, because ARM is entered on the next cycle.
- ON: led=onehot(snapshot[idx][1:0]): 00→0001, 01→0010, 10→0100, 11→1000.
  - If snapshot[idx][2]=1, led=0000 and the unassigned_seen flag sets; the flag is cleared on the next accepted start.
  - On pulse go to OFF.
- OFF: led=0.
  - On pulse: if idx==0 go to DONE, else idx<=idx-1 and go to ON.
- DONE: done=1 for exactly one cycle, led=0, then IDLE. busy drops in the IDLE cycle.
- Latency:
  - With timer period P cycles and restart at t, first colour lights at t+P+1.
  - Total playback is 2·length·P plus alignment cycles.
- Live changes to segment and length after start do not affect playback (snapshot).
- start while not IDLE is dropped, with no queuing.
- reset mid-playback: IDLE next cycle and led=0000 immediately registered. All outputs are registered.
- unassigned_seen is internal, exposed only under assertions.

Optional Feature:
- Macro SEQ_PLAYER_GAP_EN.
- Defined: ON/OFF alternation as above (blank gap between colours, so repeated colours are distinguishable).
- Undefined:
  - OFF state removed. In ON, pulse with idx!=0 decrements idx and stays in ON; pulse with idx==0 goes to DONE.
  - Playback time is length·P.

Decomposition:
- Package simon_pkg holds:
  - colour_t (logic [2:0])
  - COLOUR_UNASSIGNED = 3'b100
  - MAX_ROUNDS = 32
  - play_state_t enum {IDLE, ARM, ON, OFF, DONE}
  - LED_W
- One sub-module, colour_decoder: combinational colour_t → 4-bit one-hot with blank on unassigned. Shared later by the input checker and the LED driver.

Test Plan:
- Pulse every 4 cycles; segment[2:0]={01,10,00} (segment[0]=01); length=3; start → led sequence 0001, 0000, 0100, 0000, 0010, 0000, each held 4 cycles; done one cycle after final OFF pulse; busy high throughout.
- length=0, start → no timer_restart, done at cycle+1, led stays 0000, busy high one cycle.
- Mid-playback: change segment to all 11 and pulse start → led continues the original snapshot; start dropped; done count = 1.
- Reset asserted during ON with led=0100 → next cycle led=0000, busy=0, state IDLE; a following start with length=1, segment[0]=11 plays 1000.
- length=40, all segments 10 → exactly 32 flashes of 0100; segment[5] bit2 set → the flash for idx 5 is 0000 and unassigned_seen=1.
- With SEQ_PLAYER_GAP_EN undefined, length=2, segment={10,00} → led 0001 for P cycles then 0100 for P cycles, no blank between; done after the second pulse.
